mult_div_unit: RTL and testbench
================================

# mult_div_unit

Iterative 32-bit multiply/divide unit for the pipelined MIPS core. It sits beside the ALU in the execute stage and owns the HI/LO architectural registers. Its `lo`/`hi` outputs feed the ALU's fourth result-mux input and the MFHI/MFLO path. It performs MULT, MULTU, DIV and DIVU over multiple cycles with a start/busy/done handshake, and it takes single-cycle MTHI/MTLO writes.

## Interface
Parameters:
- `WIDTH`, 32: operand width; HI and LO are each `WIDTH` bits.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low; clears all state.
- `a`  in  WIDTH  rs operand (dividend, multiplicand, MTHI/MTLO data).
- `b`  in  WIDTH  rt operand (divisor, multiplier).
- `op`  in  3  `mdu_op_t`: MULT, MULTU, DIV, DIVU, MTHI, MTLO.
- `start`  in  1  request; sampled on the rising edge.
- `cancel`  in  1  pipeline flush; aborts an in-flight operation.
- `busy`  out  1  operation in flight; the pipeline stalls on MFHI/MFLO and MDU ops while high.
- `done`  out  1  one-cycle pulse; `hi`/`lo` hold the new result.
- `hi`  out  WIDTH  HI register.
- `lo`  out  WIDTH  LO register.

## Operation
- States: IDLE, CALC, FIX.
- IDLE, `start=1`, op is MULT/MULTU/DIV/DIVU:
  - Latch |a| and |b|. Signed ops take the two's-complement magnitude; unsigned ops take the raw value.
  - Latch the result-sign flags.
  - Load the step counter with `WIDTH-1`, clear the accumulator, go to CALC.
- IDLE, `start=1`, op is MTHI/MTLO: write `a` to `hi`/`lo` at that edge. `busy` stays low and `done` does not pulse.
- CALC: one radix-2 step per cycle. Exit to FIX when the counter reaches 0, giving exactly `WIDTH` steps.
  - Multiply: shift-add, producing a 2·WIDTH-bit unsigned product.
  - Divide: restoring shift/trial-subtract, producing an unsigned quotient and remainder.
- FIX: apply the sign fix-up, write `hi`/`lo`, return to IDLE.
  - MULT: negate the 64-bit product iff sign(a)≠sign(b). `hi` gets the upper half, `lo` the lower half.
  - DIV: `lo` = quotient, negated iff sign(a)≠sign(b). `hi` = remainder, negated iff a<0 (remainder takes the dividend's sign).
  - DIVU/MULTU: no fix-up.
- Divide by zero (b=0, DIV or DIVU): normal latency, no fix-up. Result is `lo`=all-ones, `hi`=a unchanged.
- Signed overflow, DIV 0x80000000 / 0xFFFFFFFF: `lo`=0x80000000, `hi`=0. This falls out of the magnitude arithmetic with truncation.
- `start` while busy: ignored, including MTHI/MTLO. There is no queueing.
- `cancel` in CALC or FIX: return to IDLE at that edge. `hi`/`lo` unchanged, no `done`.
- `cancel` in IDLE: suppresses a same-cycle `start`.

## Timing
- Reset values: `hi`=0, `lo`=0, `busy`=0, `done`=0, state IDLE, counter 0.
- `start` accepted at edge N:
  - `busy` is high from after edge N until after edge N+33.
  - Edges N+1 through N+32 are the CALC steps; edge N+33 is FIX.
  - `hi`, `lo` and `done=1` all become visible after edge N+33, in the same cycle. `busy` is low in that cycle.
- `done` is registered and lasts exactly one cycle.
- A new `start` is accepted in the `done` cycle, giving a back-to-back throughput of one op per 34 cycles.
- MTHI/MTLO latency is one edge.
- `busy` is registered, with no combinational path from `start`.
- Reset asserted mid-operation: immediate clear to reset values, no `done`.

## Structure
- Package `mdu_pkg` holds:
  - `mdu_op_t`, with enum values MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5.
  - `mdu_state_t`, with values IDLE, CALC, FIX.
  - `MDU_STEPS` = 32.
- One natural combinational sub-module, `mdu_step`: a single radix-2 iteration (conditional add-and-shift for multiply, trial-subtract-and-shift for divide), selected by a mode bit.
- Counter, FSM, magnitude/sign capture, fix-up and the HI/LO registers all live in `mult_div_unit`.

## Test plan
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF, start at edge N → `done` after N+33 with `hi`=0xFFFFFFFE, `lo`=0x00000001. `busy` is high for exactly 33 cycles.
- MULT a=0xFFFFFFFD (−3), b=7 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB (−21).
- DIV a=0xFFFFFFF9 (−7), b=2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. DIVU a=7, b=2 → `lo`=3, `hi`=1.
- DIV a=0x80000000, b=0xFFFFFFFF → `lo`=0x80000000, `hi`=0. DIVU a=5, b=0 → `lo`=0xFFFFFFFF, `hi`=5.
- MTLO a=0x1234, then MULTU 3×4 started; at cycle 10 pulse `start` (MTHI) → ignored. At cycle 12 pulse `cancel` → `busy` low the next cycle, no `done`, `lo`=0x1234 and `hi`=0 unchanged.
- Start a DIVU and drop `reset` at cycle 20 → outputs are 0 immediately. After release, MULTU 2×3 gives `lo`=6, `hi`=0 at the normal latency.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package mdu_pkg;

    localparam int unsigned MDU_STEPS = 32;

    typedef enum logic [2:0] {
        MULT  = 3'd0,
        MULTU = 3'd1,
        DIV   = 3'd2,
        DIVU  = 3'd3,
        MTHI  = 3'd4,
        MTLO  = 3'd5
    } mdu_op_t;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } mdu_state_t;

endpackage

// File: rtl/mdu_step.sv
// One radix-2 iteration: shift-add for multiply, restoring trial-subtract for divide.
module mdu_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             is_div_i,
    input  logic [WIDTH-1:0] acc_hi_i,
    input  logic [WIDTH-1:0] acc_lo_i,
    input  logic [WIDTH-1:0] operand_i,
    output logic [WIDTH-1:0] acc_hi_o,
    output logic [WIDTH-1:0] acc_lo_o
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             fits;

    always_comb begin
        // Multiply: acc_lo holds the remaining multiplier bits, product grows in from the top.
        sum = {1'b0, acc_hi_i} + {1'b0, (acc_lo_i[0] ? operand_i : '0)};

        // Divide: acc_hi is the partial remainder, acc_lo shifts dividend out / quotient in.
        shifted = {acc_hi_i, acc_lo_i[WIDTH-1]};
        fits    = shifted >= {1'b0, operand_i};
        diff    = shifted[WIDTH-1:0] - operand_i;

        if (is_div_i) begin
            acc_hi_o = fits ? diff : shifted[WIDTH-1:0];
            acc_lo_o = {acc_lo_i[WIDTH-2:0], fits};
        end else begin
            acc_hi_o = sum[WIDTH:1];
            acc_lo_o = {sum[0], acc_lo_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers, with MTHI/MTLO writes.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  mdu_op_t          op,
    input  logic             start,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CntW = $clog2(WIDTH);

    mdu_state_t       state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic             is_div_q, is_div_d;
    logic             neg_q_q, neg_q_d;
    logic             neg_r_q, neg_r_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             is_arith, is_signed, op_div, div_zero, a_neg, b_neg;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH-1:0] step_hi, step_lo;
    logic [2*WIDTH-1:0] prod, prod_fix;

    mdu_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .is_div_i (is_div_q),
        .acc_hi_i (acc_hi_q),
        .acc_lo_i (acc_lo_q),
        .operand_i(opnd_q),
        .acc_hi_o (step_hi),
        .acc_lo_o (step_lo)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q    <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            opnd_q   <= '0;
            is_div_q <= 1'b0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            opnd_q   <= opnd_d;
            is_div_q <= is_div_d;
            neg_q_q  <= neg_q_d;
            neg_r_q  <= neg_r_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start && !cancel && is_arith) state_d = CALC;
            CALC: begin
                if (cancel) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    state_d = FIX;
                end
            end
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        is_arith  = (op == MULT) || (op == MULTU) || (op == DIV) || (op == DIVU);
        is_signed = (op == MULT) || (op == DIV);
        op_div    = (op == DIV) || (op == DIVU);
        div_zero  = op_div && (b == '0);
        a_neg     = is_signed && a[WIDTH-1];
        b_neg     = is_signed && b[WIDTH-1];
        // Divide by zero keeps the raw dividend so the remainder comes out as a unchanged.
        mag_a     = (a_neg && !div_zero) ? -a : a;
        mag_b     = b_neg ? -b : b;

        prod      = {acc_hi_q, acc_lo_q};
        prod_fix  = neg_q_q ? -prod : prod;

        cnt_d    = cnt_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        opnd_d   = opnd_q;
        is_div_d = is_div_q;
        neg_q_d  = neg_q_q;
        neg_r_d  = neg_r_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start && !cancel) begin
                    if (is_arith) begin
                        cnt_d    = CntW'(WIDTH - 1);
                        acc_hi_d = '0;
                        acc_lo_d = op_div ? mag_a : mag_b;
                        opnd_d   = op_div ? mag_b : mag_a;
                        is_div_d = op_div;
                        neg_q_d  = !div_zero && (a_neg != b_neg);
                        neg_r_d  = !div_zero && a_neg;
                    end else if (op == MTHI) begin
                        hi_d = a;
                    end else if (op == MTLO) begin
                        lo_d = a;
                    end
                end
            end
            CALC: begin
                if (!cancel) begin
                    acc_hi_d = step_hi;
                    acc_lo_d = step_lo;
                    if (cnt_q != '0) cnt_d = cnt_q - CntW'(1);
                end
            end
            FIX: begin
                if (!cancel) begin
                    done_d = 1'b1;
                    if (is_div_q) begin
                        lo_d = neg_q_q ? -acc_lo_q : acc_lo_q;
                        hi_d = neg_r_q ? -acc_hi_q : acc_hi_q;
                    end else begin
                        hi_d = prod_fix[2*WIDTH-1:WIDTH];
                        lo_d = prod_fix[WIDTH-1:0];
                    end
                end
            end
            default: ;
        endcase

        busy_d = (state_d != IDLE);
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Randomized self-checking bench for mult_div_unit against an arithmetic reference model.
module tb_mult_div_unit;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    mdu_op_t     op = MULT;
    logic        start = 1'b0;
    logic        cancel = 1'b0;
    logic        busy, done;
    logic [31:0] hi, lo;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    mult_div_unit #(
        .WIDTH(32)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .a     (a),
        .b     (b),
        .op    (op),
        .start (start),
        .cancel(cancel),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Architectural result as {hi, lo}, straight from the instruction definitions.
    function automatic logic [63:0] ref_result(input mdu_op_t o, input logic [31:0] x,
                                               input logic [31:0] y);
        longint sx, sy, q, m;
        logic [63:0] r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        r  = '0;
        case (o)
            MULT:  r = 64'(sx * sy);
            MULTU: r = {32'b0, x} * {32'b0, y};
            DIV: begin
                if (y == 0) begin
                    r = {x, 32'hFFFF_FFFF};
                end else begin
                    q = sx / sy;
                    m = sx % sy;
                    r = {m[31:0], q[31:0]};
                end
            end
            DIVU:    r = (y == 0) ? {x, 32'hFFFF_FFFF} : {x % y, x / y};
            default: r = '0;
        endcase
        return r;
    endfunction

    // Timing model: an accepted op completes MDU_STEPS+1 edges later unless cancelled.
    logic [31:0] m_hi = '0, m_lo = '0;
    logic        m_busy = 1'b0, m_done = 1'b0;
    int          m_rem = 0;
    logic [63:0] m_pend = '0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_hi = '0; m_lo = '0; m_busy = 1'b0; m_done = 1'b0; m_rem = 0;
        end else begin
            m_done = 1'b0;
            if (m_rem > 0) begin
                if (cancel) begin
                    m_rem = 0;
                end else begin
                    m_rem--;
                    if (m_rem == 0) begin
                        {m_hi, m_lo} = m_pend;
                        m_done = 1'b1;
                    end
                end
            end else if (start && !cancel) begin
                case (op)
                    MTHI: m_hi = a;
                    MTLO: m_lo = a;
                    default: begin
                        m_pend = ref_result(op, a, b);
                        m_rem  = MDU_STEPS + 1;
                    end
                endcase
            end
            m_busy = (m_rem > 0);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc busy", 64'(busy), 64'(m_busy));
            chk("cyc done", 64'(done), 64'(m_done));
            chk("cyc hi", 64'(hi), 64'(m_hi));
            chk("cyc lo", 64'(lo), 64'(m_lo));
        end
    end

    task automatic pulse_op(input mdu_op_t o, input logic [31:0] xa, input logic [31:0] xb);
        @(negedge clk);
        op = o; a = xa; b = xb; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_op(input mdu_op_t o, input logic [31:0] xa, input logic [31:0] xb,
                          input logic [31:0] ehi, input logic [31:0] elo, input string name);
        int nbusy;
        bit seen;
        pulse_op(o, xa, xb);
        nbusy = 0;
        seen  = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            if (done) begin
                seen = 1'b1;
                chk({name, " hi"}, 64'(hi), 64'(ehi));
                chk({name, " lo"}, 64'(lo), 64'(elo));
                chk({name, " busy cycles"}, 64'(nbusy), 64'd33);
                chk({name, " busy in done cycle"}, 64'(busy), 64'd0);
            end else begin
                if (busy) nbusy++;
                @(negedge clk);
            end
        end
        chk({name, " done seen"}, 64'(seen), 64'd1);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h1;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int ndone;
        #1 reset = 1'b0;
        #2;
        chk("reset hi", 64'(hi), 64'd0);
        chk("reset lo", 64'(lo), 64'd0);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        chk("model multu", ref_result(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF),
            64'hFFFF_FFFE_0000_0001);
        chk("model div ovf", ref_result(DIV, 32'h8000_0000, 32'hFFFF_FFFF),
            64'h0000_0000_8000_0000);
        chk("model div neg", ref_result(DIV, 32'hFFFF_FFF9, 32'd2), 64'hFFFF_FFFF_FFFF_FFFD);
        #19 reset = 1'b1;
        chk_en = 1'b1;

        // MTLO, then an ignored MTHI while busy, then cancel mid-multiply.
        pulse_op(MTLO, 32'h1234, 32'h0);
        pulse_op(MULTU, 32'd3, 32'd4);
        repeat (8) @(negedge clk);
        op = MTHI; a = 32'hDEAD_BEEF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        chk("cancel busy", 64'(busy), 64'd0);
        chk("cancel lo", 64'(lo), 64'h1234);
        chk("cancel hi", 64'(hi), 64'd0);
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) ndone++;
            @(negedge clk);
        end
        chk("cancel no done", 64'(ndone), 64'd0);

        run_op(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu max");
        run_op(MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult -3*7");
        run_op(DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div -7/2");
        run_op(DIVU, 32'd7, 32'd2, 32'd1, 32'd3, "divu 7/2");
        run_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, "div ovf");
        run_op(DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, "divu by 0");
        run_op(DIV, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, "div by 0");

        // Randomized traffic: back-to-back starts, starts while busy, random cancels.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            start  = ($urandom_range(0, 3) == 0);
            op     = mdu_op_t'($urandom_range(0, 5));
            a      = pick();
            b      = pick();
            cancel = ($urandom_range(0, 49) == 0);
        end
        @(negedge clk);
        start = 1'b0; cancel = 1'b0;
        repeat (40) @(negedge clk);

        // Reset dropped mid-divide clears everything immediately.
        pulse_op(MTHI, 32'hCAFE_0001, 32'h0);
        pulse_op(DIVU, 32'd1000, 32'd7);
        repeat (19) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("async rst hi", 64'(hi), 64'd0);
        chk("async rst lo", 64'(lo), 64'd0);
        chk("async rst busy", 64'(busy), 64'd0);
        chk("async rst done", 64'(done), 64'd0);
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        run_op(MULTU, 32'd2, 32'd3, 32'd0, 32'd6, "multu after rst");
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
